// File: rtl/axis_uart_bridge_rx_ext.sv
// ---------------------------------------------------------------------------
// axis_uart_bridge_rx_ext
//   UART receiver feeding an AXI-Stream master. Characters with compile-time
//   framing (5..8 data bits, none/odd/even parity, 1 or 2 stop bits) are
//   recovered with a 3-sample majority vote at mid-bit. Good characters are
//   packed into N_BYTES byte lanes. A word closes when all lanes are full
//   (TLAST=0) or when the line has been idle for IDLE_TIMEOUT bit periods with
//   a partial word pending (TLAST=1). Closed words go through a QUEUE_DEPTH
//   word FIFO to the AXIS port.
//
// Ports
//   clk, resetn          system clock, synchronous active-low reset
//   UART_RX              asynchronous serial input, idle high
//   M_AXIS_TDATA/TKEEP   packed characters (lane 0 first) / valid lanes
//   M_AXIS_TVALID/TLAST  word available / word closed by idle timeout
//   M_AXIS_TREADY        downstream accept
//   STS_FRAME_ERR        1-clk pulse, stop bit sampled low
//   STS_PARITY_ERR       1-clk pulse, parity mismatch
//   STS_OVERFLOW         1-clk pulse, closed word dropped because FIFO full
//   STS_DROP_CNT         saturating count of dropped words and bad chars
//   dbg_state            receive FSM state (0 idle,1 start,2 data,3 parity,4 stop)
//
// Handshake: a word transfers on a rising clk edge where M_AXIS_TVALID and
// M_AXIS_TREADY are both high. While TVALID is high and TREADY low, TDATA,
// TKEEP and TLAST hold their values. TVALID never depends on TREADY.
// ---------------------------------------------------------------------------
module axis_uart_bridge_rx_ext #(
  parameter int UART_SPEED   = 115200,
  parameter int FREQ_HZ      = 100000000,
  parameter int N_BYTES      = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_TIMEOUT = 16,
  parameter int QUEUE_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 UART_RX,
  output logic [N_BYTES*8-1:0] M_AXIS_TDATA,
  output logic [N_BYTES-1:0]   M_AXIS_TKEEP,
  output logic                 M_AXIS_TVALID,
  output logic                 M_AXIS_TLAST,
  input  logic                 M_AXIS_TREADY,
  output logic                 STS_FRAME_ERR,
  output logic                 STS_PARITY_ERR,
  output logic                 STS_OVERFLOW,
  output logic [15:0]          STS_DROP_CNT,
  output logic [2:0]           dbg_state
);

  localparam int CPB = FREQ_HZ / UART_SPEED;
  localparam int MID = CPB / 2;
  localparam int TW  = $clog2(CPB);
  localparam int FW  = $clog2(N_BYTES + 1);
  localparam int AW  = $clog2(QUEUE_DEPTH);
  localparam int WW  = N_BYTES * 8;

  localparam logic [TW-1:0] T_LAST   = TW'(CPB - 1);
  localparam logic [TW-1:0] T_M1     = TW'(MID - 1);
  localparam logic [TW-1:0] T_M      = TW'(MID);
  localparam logic [TW-1:0] T_P1     = TW'(MID + 1);
  localparam logic [2:0]    DB_LAST  = 3'(DATA_BITS - 1);
  localparam logic          ST_LAST  = 1'(STOP_BITS - 1);
  localparam logic [FW-1:0] LANE_LST = FW'(N_BYTES - 1);
  localparam logic [15:0]   IDLE_TO  = 16'(IDLE_TIMEOUT);
  localparam logic [15:0]   IDLE_TM1 = 16'(IDLE_TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------- input synchroniser and edge detect ----------------
  logic rx_meta, rx_sync, rx_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_d    <= rx_sync;
    end
  end

  logic rx_fall;
  assign rx_fall = rx_d & ~rx_sync;

  // ---------------- receive FSM ----------------
  state_t        state;
  logic [TW-1:0] timer;
  logic          s0, s1;
  logic          maj;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shreg;
  logic          par_err;
  logic          frm_err;
  logic          char_stb;
  logic [7:0]    char_byte;
  logic          sts_frame, sts_parity;
  logic          stop_bad;
  logic          ones;

  // Third sample is the live synced value at MID+1.
  assign maj      = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  assign stop_bad = frm_err | ~maj;
  assign ones     = (^shreg) ^ maj;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      timer      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      char_stb   <= 1'b0;
      char_byte  <= '0;
      sts_frame  <= 1'b0;
      sts_parity <= 1'b0;
    end else begin
      char_stb   <= 1'b0;
      sts_frame  <= 1'b0;
      sts_parity <= 1'b0;
      if (state == S_IDLE) begin
        timer <= '0;
        if (rx_fall) begin
          state    <= S_START;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          shreg    <= '0;
          par_err  <= 1'b0;
          frm_err  <= 1'b0;
        end
      end else begin
        timer <= (timer == T_LAST) ? '0 : timer + TW'(1);
        if (timer == T_M1) s0 <= rx_sync;
        if (timer == T_M)  s1 <= rx_sync;
        // State changes happen at the MID+1 decision point; the timer keeps
        // running so the next bit's samples still land at its own mid-bit.
        if (timer == T_P1) begin
          case (state)
            S_START: state <= maj ? S_IDLE : S_DATA;
            S_DATA: begin
              shreg[bit_idx] <= maj;
              if (bit_idx == DB_LAST) begin
                state <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
            S_PARITY: begin
              par_err <= (PARITY == 1) ? ~ones : ones;
              state   <= S_STOP;
            end
            S_STOP: begin
              if (stop_idx == ST_LAST) begin
                // Leave half a bit early so a back-to-back start edge is seen.
                state <= S_IDLE;
                if (stop_bad || par_err) begin
                  sts_frame  <= stop_bad;
                  sts_parity <= par_err;
                end else begin
                  char_stb  <= 1'b1;
                  char_byte <= shreg;
                end
              end else begin
                stop_idx <= 1'b1;
                frm_err  <= stop_bad;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign dbg_state      = state;
  assign STS_FRAME_ERR  = sts_frame;
  assign STS_PARITY_ERR = sts_parity;

  // ---------------- idle timer ----------------
  // Counts whole bit periods spent in IDLE; fires once and then holds until
  // the FSM leaves IDLE again.
  logic [TW-1:0] idle_clk;
  logic [15:0]   idle_bits;
  logic          timeout_stb;

  always_ff @(posedge clk) begin
    if (!resetn || state != S_IDLE) begin
      idle_clk    <= '0;
      idle_bits   <= '0;
      timeout_stb <= 1'b0;
    end else begin
      timeout_stb <= 1'b0;
      if (IDLE_TIMEOUT != 0 && idle_bits != IDLE_TO) begin
        if (idle_clk == T_LAST) begin
          idle_clk  <= '0;
          idle_bits <= idle_bits + 16'd1;
          if (idle_bits == IDLE_TM1) timeout_stb <= 1'b1;
        end else begin
          idle_clk <= idle_clk + TW'(1);
        end
      end
    end
  end

  // ---------------- byte-lane packer ----------------
  logic [WW-1:0]      pack_data;
  logic [FW-1:0]      fill;
  logic [WW-1:0]      char_word;
  logic [N_BYTES-1:0] part_keep;
  logic               push_stb;
  logic [WW-1:0]      push_data;
  logic [N_BYTES-1:0] push_keep;
  logic               push_last;

  always_comb begin
    char_word = pack_data;
    part_keep = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (fill == FW'(i)) char_word[i*8 +: 8] = char_byte;
      if (FW'(i) < fill)  part_keep[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pack_data <= '0;
      fill      <= '0;
      push_stb  <= 1'b0;
      push_data <= '0;
      push_keep <= '0;
      push_last <= 1'b0;
    end else begin
      push_stb <= 1'b0;
      if (char_stb) begin
        if (fill == LANE_LST) begin
          push_stb  <= 1'b1;
          push_data <= char_word;
          push_keep <= '1;
          push_last <= 1'b0;
          pack_data <= '0;
          fill      <= '0;
        end else begin
          pack_data <= char_word;
          fill      <= fill + FW'(1);
        end
      end else if (timeout_stb && fill != '0) begin
        // Unused lanes are already zero because the packer clears on push.
        push_stb  <= 1'b1;
        push_data <= pack_data;
        push_keep <= part_keep;
        push_last <= 1'b1;
        pack_data <= '0;
        fill      <= '0;
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [WW-1:0]      mem_data [QUEUE_DEPTH];
  logic [N_BYTES-1:0] mem_keep [QUEUE_DEPTH];
  logic               mem_last [QUEUE_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               full, do_push, do_pop, ovf;

  // Full is taken before any same-cycle pop, so a push into a full FIFO drops.
  assign full    = (count == DEPTH_C);
  assign do_push = push_stb & ~full;
  assign do_pop  = M_AXIS_TVALID & M_AXIS_TREADY;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= push_data;
      mem_keep[wr_ptr] <= push_keep;
      mem_last[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= push_stb & full;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign M_AXIS_TVALID = (count != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? mem_data[rd_ptr] : '0;
  assign M_AXIS_TKEEP  = M_AXIS_TVALID ? mem_keep[rd_ptr] : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID ? mem_last[rd_ptr] : 1'b0;
  assign STS_OVERFLOW  = ovf;

  // ---------------- drop counter ----------------
  // A bad char and an overflow can pulse together; both are counted.
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt;

  assign drop_inc = {1'b0, sts_frame | sts_parity} + {1'b0, ovf};
  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign STS_DROP_CNT = drop_cnt;

endmodule

// File: tb/tb_axis_uart_bridge_rx_ext.sv
// Bench for axis_uart_bridge_rx_ext: one 8N1 instance (dut_a) and one 8E1
// instance (dut_p), both 16 clk/bit, 4 lanes, 4-word FIFO.
module tb_axis_uart_bridge_rx_ext;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        rx_a = 1'b1, rx_p = 1'b1;
  logic        tready_a = 1'b1, tready_p = 1'b1;
  logic [31:0] tdata_a, tdata_p;
  logic [3:0]  tkeep_a, tkeep_p;
  logic        tvalid_a, tvalid_p, tlast_a, tlast_p;
  logic        frm_a_o, par_a_o, ovf_a_o, frm_p_o, par_p_o, ovf_p_o;
  logic [15:0] drop_a, drop_p;
  logic [2:0]  dbg_a, dbg_p;

  axis_uart_bridge_rx_ext #(
    .UART_SPEED(100), .FREQ_HZ(1600), .N_BYTES(4), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .IDLE_TIMEOUT(16), .QUEUE_DEPTH(4)
  ) dut_a (
    .clk(clk), .resetn(resetn), .UART_RX(rx_a),
    .M_AXIS_TDATA(tdata_a), .M_AXIS_TKEEP(tkeep_a), .M_AXIS_TVALID(tvalid_a),
    .M_AXIS_TLAST(tlast_a), .M_AXIS_TREADY(tready_a),
    .STS_FRAME_ERR(frm_a_o), .STS_PARITY_ERR(par_a_o), .STS_OVERFLOW(ovf_a_o),
    .STS_DROP_CNT(drop_a), .dbg_state(dbg_a)
  );

  axis_uart_bridge_rx_ext #(
    .UART_SPEED(100), .FREQ_HZ(1600), .N_BYTES(4), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .IDLE_TIMEOUT(16), .QUEUE_DEPTH(4)
  ) dut_p (
    .clk(clk), .resetn(resetn), .UART_RX(rx_p),
    .M_AXIS_TDATA(tdata_p), .M_AXIS_TKEEP(tkeep_p), .M_AXIS_TVALID(tvalid_p),
    .M_AXIS_TLAST(tlast_p), .M_AXIS_TREADY(tready_p),
    .STS_FRAME_ERR(frm_p_o), .STS_PARITY_ERR(par_p_o), .STS_OVERFLOW(ovf_p_o),
    .STS_DROP_CNT(drop_p), .dbg_state(dbg_p)
  );

  // ---------------- scoreboard state ----------------
  // Entries are {tlast, tkeep, tdata}.
  logic [36:0] exp_q[$];
  logic [36:0] exp_p_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int frm_a = 0, par_a = 0, ovf_a = 0;
  int frm_p = 0, par_p = 0, ovf_p = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitors ----------------
  // Inputs change on negedge; sampling 1 time unit later sees the values the
  // next rising edge will use.
  always @(negedge clk) begin
    #1;
    if (resetn) begin
      if (frm_a_o) frm_a++;
      if (par_a_o) par_a++;
      if (ovf_a_o) ovf_a++;
      if (tvalid_a && tready_a) begin
        if (exp_q.size() == 0) check("a_unexpected_word", {27'd0, tlast_a, tkeep_a, tdata_a}, 64'd0);
        else check("a_word", {27'd0, tlast_a, tkeep_a, tdata_a}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (resetn) begin
      if (frm_p_o) frm_p++;
      if (par_p_o) par_p++;
      if (ovf_p_o) ovf_p++;
      if (tvalid_p && tready_p) begin
        if (exp_p_q.size() == 0) check("p_unexpected_word", {27'd0, tlast_p, tkeep_p, tdata_p}, 64'd0);
        else check("p_word", {27'd0, tlast_p, tkeep_p, tdata_p}, {27'd0, exp_p_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx_a = v;
    repeat (CPB) @(negedge clk);
  endtask

  // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send_char(input bit sel, input logic [7:0] d, input int par, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par >= 0) drive_bit(sel, par[0]);
    drive_bit(sel, stop);
    if (!stop) drive_bit(sel, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic wait_empty(input bit sel, input int budget, input string name);
    int i;
    i = 0;
    while (i < budget && (sel ? exp_p_q.size() : exp_q.size()) != 0) begin
      @(negedge clk);
      i++;
    end
    check(name, sel ? exp_p_q.size() : exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (4) @(negedge clk);
    // Reset state
    check("rst_tvalid", tvalid_a, 0);
    check("rst_tdata", tdata_a, 0);
    check("rst_tkeep", tkeep_a, 0);
    check("rst_tlast", tlast_a, 0);
    check("rst_sts", {frm_a_o, par_a_o, ovf_a_o}, 0);
    check("rst_drop", drop_a, 0);
    resetn = 1'b1;
    idle_bits(2);

    // 1: four 8N1 chars back-to-back -> one full word
    exp_q.push_back({1'b0, 4'hF, 32'h44332211});
    send_char(0, 8'h11, -1, 1'b1);
    send_char(0, 8'h22, -1, 1'b1);
    send_char(0, 8'h33, -1, 1'b1);
    send_char(0, 8'h44, -1, 1'b1);
    wait_empty(0, 100, "t1_drain");
    idle_bits(20);
    check("t1_no_sts", {frm_a[15:0], par_a[15:0], ovf_a[15:0]}, 0);

    // 2: two chars then idle timeout -> partial word with TLAST
    exp_q.push_back({1'b1, 4'h3, 32'h00005AA5});
    send_char(0, 8'hA5, -1, 1'b1);
    send_char(0, 8'h5A, -1, 1'b1);
    idle_bits(18);
    wait_empty(0, 200, "t2_drain");

    // 3: even parity instance, 0x07 has three ones -> parity bit must be 1
    send_char(1, 8'h07, 0, 1'b1);
    idle_bits(2);
    check("t3_par_pulse", par_p, 1);
    check("t3_drop", drop_p, 1);
    check("t3_no_word", tvalid_p, 0);
    exp_p_q.push_back({1'b1, 4'h1, 32'h00000007});
    send_char(1, 8'h07, 1, 1'b1);
    idle_bits(18);
    wait_empty(1, 200, "t3_drain");
    check("t3_no_frame", frm_p, 0);

    // 4: stop bit low -> frame error, then a 3-clk glitch -> false start
    send_char(0, 8'h3C, -1, 1'b0);
    idle_bits(2);
    check("t4_frame_pulse", frm_a, 1);
    check("t4_drop", drop_a, 1);
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    idle_bits(20);
    check("t4_glitch_sts", {frm_a[15:0], par_a[15:0], ovf_a[15:0]}, {16'd1, 16'd0, 16'd0});
    check("t4_state_idle", dbg_a, 0);
    check("t4_no_word", tvalid_a, 0);

    // 5: TREADY low, 20 chars -> 4 words queued, 5th dropped
    tready_a = 1'b0;
    exp_q.push_back({1'b0, 4'hF, 32'h04030201});
    exp_q.push_back({1'b0, 4'hF, 32'h08070605});
    exp_q.push_back({1'b0, 4'hF, 32'h0C0B0A09});
    exp_q.push_back({1'b0, 4'hF, 32'h100F0E0D});
    for (int i = 1; i <= 20; i++) send_char(0, 8'(i), -1, 1'b1);
    idle_bits(2);
    check("t5_ovf_pulse", ovf_a, 1);
    check("t5_drop", drop_a, 2);
    check("t5_hold_data", tdata_a, 32'h04030201);
    idle_bits(4);
    check("t5_hold_data_stable", {tvalid_a, tkeep_a, tdata_a}, {1'b1, 4'hF, 32'h04030201});
    tready_a = 1'b1;
    wait_empty(0, 50, "t5_drain");
    @(negedge clk);
    check("t5_empty", tvalid_a, 0);

    // 6: reset in the middle of the second char's data bits
    send_char(0, 8'h77, -1, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    rx_a = 1'b1;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("t6_tvalid", tvalid_a, 0);
    check("t6_drop", drop_a, 0);
    check("t6_state", dbg_a, 0);
    exp_q.push_back({1'b1, 4'h1, 32'h00000099});
    send_char(0, 8'h99, -1, 1'b1);
    idle_bits(18);
    wait_empty(0, 200, "t6_drain");

    // Final bookkeeping
    idle_bits(2);
    check("end_q_a", exp_q.size(), 0);
    check("end_q_p", exp_p_q.size(), 0);
    check("end_no_parity_a", par_a, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
